// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the memory stage and its alignment helper.
//   - OP_* : load/store opcodes (instruction bits [31:26])
//   - size_e : access width decoded from the opcode
//   - state_e : memory-stage FSM states
//   - op_size() : opcode -> access width (unknown opcodes are word accesses)
package pipe_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic size_e op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: purely combinational sizing logic for a 32-bit little-endian bus.
// Ports:
//   opcode_i     [5:0]  instruction opcode, selects size and sign
//   addr_lo_i    [1:0]  low address bits (byte lane)
//   store_data_i [31:0] raw store data
//   load_data_i  [31:0] raw bus read data
//   misaligned_o        half with addr[0]=1 or word with addr[1:0]!=0
//   be_o         [3:0]  byte enables
//   wdata_o      [31:0] store data replicated across lanes
//   rdata_o      [31:0] addressed lane extracted and sign/zero extended
module mem_align
    import pipe_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_data_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    size_e       size;
    logic        sign_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign size     = op_size(opcode_i);
    assign sign_ext = (opcode_i == OP_LB) || (opcode_i == OP_LH);

    always_comb begin
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        rdata_o      = load_data_i;

        case (addr_lo_i)
            2'd0:    byte_lane = load_data_i[7:0];
            2'd1:    byte_lane = load_data_i[15:8];
            2'd2:    byte_lane = load_data_i[23:16];
            default: byte_lane = load_data_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? load_data_i[31:16] : load_data_i[15:0];

        case (size)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
                rdata_o = sign_ext ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            end
            SZ_HALF: begin
                misaligned_o = addr_lo_i[0];
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{store_data_i[15:0]}};
                rdata_o      = sign_ext ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between the EXE/MEM and MEM/WB registers.
// Ports:
//   CLK, RESET (async, active low)
//   *_PR            EXE pipeline register outputs (address/result, store data,
//                   instruction, destination, control)
//   dmem_*          data-memory request/ack bus
//   Stall_MEM       freeze EXE and earlier stages this cycle
//   *_MEM           same-cycle forwarding values back to EXE
//   *_WB            registered MEM/WB pipeline register
//   mem_fault       one-cycle pulse on misaligned access or bus timeout
//   dbg_state_o     current FSM state
// Parameter MAX_WAIT (1..255): cycles spent in WAIT before the access aborts.
//
// Bus handshake: dmem_req is the valid; dmem_ack is the ready/response. A
// transfer completes in exactly the cycle where dmem_req && dmem_ack. While
// dmem_req is high and dmem_ack is low, dmem_we/addr/wdata/be are held stable
// (upstream is frozen by Stall_MEM). dmem_ack with dmem_req low is ignored.
// A new request may start in the cycle right after a completion.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] aluResult1_PR,
    input  logic [31:0] readDataB1_PR,
    input  logic [31:0] Instr1_PR,
    input  logic [4:0]  writeRegister1_PR,
    input  logic        MemtoReg1_PR,
    input  logic        MemRead1_PR,
    input  logic        MemWrite1_PR,
    input  logic        do_writeback1_PR,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        Stall_MEM,
    output logic [31:0] Data1_MEM,
    output logic [4:0]  writeRegister1_MEM,
    output logic        do_writeback1_MEM,
    output logic [31:0] Data1_WB,
    output logic [4:0]  writeRegister1_WB,
    output logic        do_writeback1_WB,
    output logic        mem_fault,
    output state_e      dbg_state_o
);

    state_e      state_q;
    logic [7:0]  wait_cnt_q;
    logic [8:0]  wait_cnt_inc;

    logic [31:0] data_wb_q, data_wb_d;
    logic [4:0]  wreg_wb_q, wreg_wb_d;
    logic        wb_en_q, wb_en_d;
    logic        fault_q;

    logic        mem_op;
    logic        misaligned;
    logic [31:0] load_data;
    logic        issue;
    logic        in_wait;
    logic        mis_fault;
    logic        timeout_abort;
    logic        fault_now;
    logic        unused_instr;

    assign unused_instr = ^Instr1_PR[25:0];

    mem_align u_align (
        .opcode_i     (Instr1_PR[31:26]),
        .addr_lo_i    (aluResult1_PR[1:0]),
        .store_data_i (readDataB1_PR),
        .load_data_i  (dmem_rdata),
        .misaligned_o (misaligned),
        .be_o         (dmem_be),
        .wdata_o      (dmem_wdata),
        .rdata_o      (load_data)
    );

    assign mem_op    = MemRead1_PR | MemWrite1_PR;
    assign in_wait   = (state_q == ST_WAIT);
    assign issue     = (state_q == ST_IDLE) && mem_op && !misaligned;
    assign mis_fault = (state_q == ST_IDLE) && mem_op && misaligned;

    // The counter holds the number of WAIT cycles already spent; the abort
    // fires in the cycle where this one would make MAX_WAIT. An ack in that
    // same cycle wins and completes normally.
    assign wait_cnt_inc  = {1'b0, wait_cnt_q} + 9'd1;
    assign timeout_abort = in_wait && !dmem_ack && (wait_cnt_inc == 9'(MAX_WAIT));
    assign fault_now     = mis_fault | timeout_abort;

    // Gated by RESET so the request drops immediately on an async reset.
    assign dmem_req  = RESET && (issue || in_wait);
    assign dmem_we   = MemWrite1_PR;
    assign dmem_addr = {aluResult1_PR[31:2], 2'b00};
    assign Stall_MEM = dmem_req && !dmem_ack && !timeout_abort;

    assign Data1_MEM          = aluResult1_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue && !dmem_ack) begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack || timeout_abort) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A stalled cycle loads a bubble; otherwise the instruction retires into WB.
    always_comb begin
        data_wb_d = data_wb_q;
        wreg_wb_d = wreg_wb_q;
        wb_en_d   = 1'b0;
        if (!Stall_MEM) begin
            data_wb_d = MemtoReg1_PR ? load_data : aluResult1_PR;
            wreg_wb_d = writeRegister1_PR;
            wb_en_d   = do_writeback1_PR & ~fault_now;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_wb_q <= 32'h0;
            wreg_wb_q <= 5'd0;
            wb_en_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            data_wb_q <= data_wb_d;
            wreg_wb_q <= wreg_wb_d;
            wb_en_q   <= wb_en_d;
            fault_q   <= fault_now;
        end
    end

    assign Data1_WB          = data_wb_q;
    assign writeRegister1_WB = wreg_wb_q;
    assign do_writeback1_WB  = wb_en_q;
    assign mem_fault         = fault_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: reset checks, a table of single-cycle vectors,
// hand-written wait/timeout/reset sequences, and randomized transactions
// checked against an arithmetic reference model.
module tb_mem_stage;
    import pipe_pkg::*;

    localparam int unsigned MAX_WAIT = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK;
    logic        RESET;
    logic [31:0] aluResult1_PR;
    logic [31:0] readDataB1_PR;
    logic [31:0] Instr1_PR;
    logic [4:0]  writeRegister1_PR;
    logic        MemtoReg1_PR;
    logic        MemRead1_PR;
    logic        MemWrite1_PR;
    logic        do_writeback1_PR;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        Stall_MEM;
    logic [31:0] Data1_MEM;
    logic [4:0]  writeRegister1_MEM;
    logic        do_writeback1_MEM;
    logic [31:0] Data1_WB;
    logic [4:0]  writeRegister1_WB;
    logic        do_writeback1_WB;
    logic        mem_fault;
    state_e      dbg_state;

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .aluResult1_PR      (aluResult1_PR),
        .readDataB1_PR      (readDataB1_PR),
        .Instr1_PR          (Instr1_PR),
        .writeRegister1_PR  (writeRegister1_PR),
        .MemtoReg1_PR       (MemtoReg1_PR),
        .MemRead1_PR        (MemRead1_PR),
        .MemWrite1_PR       (MemWrite1_PR),
        .do_writeback1_PR   (do_writeback1_PR),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .Stall_MEM          (Stall_MEM),
        .Data1_MEM          (Data1_MEM),
        .writeRegister1_MEM (writeRegister1_MEM),
        .do_writeback1_MEM  (do_writeback1_MEM),
        .Data1_WB           (Data1_WB),
        .writeRegister1_WB  (writeRegister1_WB),
        .do_writeback1_WB   (do_writeback1_WB),
        .mem_fault          (mem_fault),
        .dbg_state_o        (dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int          tests_run = 0;
    int          failed    = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", what, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdata, input logic rd, input logic wr, input logic m2r,
                         input logic dwb, input logic [4:0] wreg, input logic ack);
        Instr1_PR         = {op, 26'($urandom)};
        aluResult1_PR     = addr;
        readDataB1_PR     = sdata;
        dmem_rdata        = rdata;
        MemRead1_PR       = rd;
        MemWrite1_PR      = wr;
        MemtoReg1_PR      = m2r;
        do_writeback1_PR  = dwb;
        writeRegister1_PR = wreg;
        dmem_ack          = ack;
    endtask

    task automatic next_edge();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        dwb;
        logic [4:0]  wreg;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_wb;
        logic        exp_fault;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input logic rd, input logic wr, input logic m2r,
                           input logic dwb, input logic [4:0] wreg, input logic exp_req,
                           input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_data, input logic exp_wb, input logic exp_fault);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.rd = rd; v.wr = wr; v.m2r = m2r; v.dwb = dwb; v.wreg = wreg;
        v.exp_req = exp_req; v.exp_we = exp_we; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_data = exp_data; v.exp_wb = exp_wb; v.exp_fault = exp_fault;
        vq.push_back(v);
    endtask

    task automatic run_table();
        vec_t v;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.op, v.addr, v.sdata, v.rdata, v.rd, v.wr, v.m2r, v.dwb, v.wreg, 1'b1);
            #2;
            check($sformatf("vec%0d_req", i), 32'(dmem_req), 32'(v.exp_req));
            check($sformatf("vec%0d_stall", i), 32'(Stall_MEM), 32'h0);
            check($sformatf("vec%0d_fwd_data", i), Data1_MEM, v.addr);
            check($sformatf("vec%0d_fwd_reg", i), 32'(writeRegister1_MEM), 32'(v.wreg));
            check($sformatf("vec%0d_fwd_wb", i), 32'(do_writeback1_MEM), 32'(v.dwb & ~v.rd));
            if (v.exp_req) begin
                check($sformatf("vec%0d_addr", i), dmem_addr, {v.addr[31:2], 2'b00});
                check($sformatf("vec%0d_we", i), 32'(dmem_we), 32'(v.exp_we));
                check($sformatf("vec%0d_be", i), 32'(dmem_be), 32'(v.exp_be));
                check($sformatf("vec%0d_wdata", i), dmem_wdata, v.exp_wdata);
            end
            next_edge();
            check($sformatf("vec%0d_wb", i), 32'(do_writeback1_WB), 32'(v.exp_wb));
            check($sformatf("vec%0d_fault", i), 32'(mem_fault), 32'(v.exp_fault));
            if (!v.exp_fault) begin
                check($sformatf("vec%0d_data", i), Data1_WB, v.exp_data);
                check($sformatf("vec%0d_wreg", i), 32'(writeRegister1_WB), 32'(v.wreg));
            end
        end
    endtask

    // ---------------- reference model helpers ----------------
    logic [5:0] rnd_ops [10];

    function automatic int nbytes_of(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    task automatic run_random(input int n);
        logic [5:0]  op;
        logic [31:0] addr, sdata, rdata, exp_data, ld, mask, ewd, got;
        logic        rd, wr, m2r, dwb, memop, misal, ok;
        logic [4:0]  wreg;
        logic [3:0]  ebe;
        int          nb, lane, w;
        for (int t = 0; t < n; t++) begin
            op    = rnd_ops[$urandom_range(0, 9)];
            addr  = $urandom;
            sdata = $urandom;
            rdata = $urandom;
            wreg  = 5'($urandom);
            nb    = nbytes_of(op);
            if ($urandom_range(0, 1) == 1) addr = addr & ~32'(nb - 1);
            if (op == 6'h00) begin
                rd = 1'b0; wr = 1'b0;
            end else if (op == OP_SB || op == OP_SH || op == OP_SW) begin
                wr = 1'b1; rd = ($urandom_range(0, 3) == 0);
            end else begin
                rd = 1'b1; wr = 1'b0;
            end
            m2r   = rd & ~wr;
            dwb   = 1'($urandom_range(0, 1));
            memop = rd | wr;
            lane  = int'(addr[1:0]);
            misal = memop && ((lane % nb) != 0);
            ok    = memop && !misal;
            ebe   = 4'(((1 << nb) - 1) << lane);
            ewd   = (nb == 1) ? 32'(sdata[7:0]) * 32'h01010101 :
                    (nb == 2) ? 32'(sdata[15:0]) * 32'h00010001 : sdata;
            mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
            ld    = (rdata >> (8 * lane)) & mask;
            if ((op == OP_LB || op == OP_LH) && ld[8 * nb - 1]) ld = ld | ~mask;
            exp_data = m2r ? ld : addr;
            if (!misal) exp_q.push_back(exp_data);
            w = ok ? int'($urandom_range(0, MAX_WAIT)) : 0;

            drive(op, addr, sdata, rdata, rd, wr, m2r, dwb, wreg, 1'b0);
            for (int k = 0; k <= w; k++) begin
                dmem_ack = ok ? (k == w) : 1'($urandom_range(0, 1));
                #2;
                check("rnd_req", 32'(dmem_req), 32'(ok));
                check("rnd_stall", 32'(Stall_MEM), 32'(k < w));
                check("rnd_fwd_wb", 32'(do_writeback1_MEM), 32'(dwb & ~rd));
                if (ok) begin
                    check("rnd_addr", dmem_addr, {addr[31:2], 2'b00});
                    check("rnd_we", 32'(dmem_we), 32'(wr));
                    check("rnd_be", 32'(dmem_be), 32'(ebe));
                    check("rnd_wdata", dmem_wdata, ewd);
                end
                next_edge();
                if (k < w) begin
                    check("rnd_bubble", 32'(do_writeback1_WB), 32'h0);
                    check("rnd_fault_wait", 32'(mem_fault), 32'h0);
                end
            end
            check("rnd_fault", 32'(mem_fault), 32'(misal));
            check("rnd_wb", 32'(do_writeback1_WB), 32'(dwb & ~misal));
            if (!misal) begin
                check("rnd_wreg", 32'(writeRegister1_WB), 32'(wreg));
                if (exp_q.size() == 0) begin
                    check("rnd_queue_nonempty", 32'h0, 32'h1);
                end else begin
                    got = exp_q.pop_front();
                    check("rnd_data", Data1_WB, got);
                end
            end
        end
    endtask

    // ---------------- main sequence ----------------
    int   stall_cnt;
    logic stalled;

    initial begin
        rnd_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'h00, 6'h0F};

        // Reset held during memory traffic.
        RESET = 1'b0;
        drive(OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            next_edge();
            check("rst_req", 32'(dmem_req), 32'h0);
            check("rst_data_wb", Data1_WB, 32'h0);
            check("rst_wreg_wb", 32'(writeRegister1_WB), 32'h0);
            check("rst_wb", 32'(do_writeback1_WB), 32'h0);
            check("rst_fault", 32'(mem_fault), 32'h0);
        end
        RESET = 1'b1;
        drive(6'h00, 32'hA5A50001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
        next_edge();
        check("rst_first_alu_data", Data1_WB, 32'hA5A50001);
        check("rst_first_alu_wreg", 32'(writeRegister1_WB), 32'd7);
        check("rst_first_alu_wb", 32'(do_writeback1_WB), 32'h1);

        // Single-cycle vectors: op addr sdata rdata rd wr m2r dwb wreg | req we be wdata data wb fault
        add_vec(6'h00,  32'h12345678, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 4'h0, 32'h0,        32'h12345678, 1'b1, 1'b0);
        add_vec(OP_LW,  32'h00000100, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
        add_vec(OP_LB,  32'h00000103, 32'h0,        32'h8070F0A5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0);
        add_vec(OP_LBU, 32'h00000101, 32'h0,        32'h8070F0A5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 4'h2, 32'h0,        32'h000000F0, 1'b1, 1'b0);
        add_vec(OP_LH,  32'h00000102, 32'h0,        32'h8070F0A5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 4'hC, 32'h0,        32'hFFFF8070, 1'b1, 1'b0);
        add_vec(OP_LHU, 32'h00000100, 32'h0,        32'h8070F0A5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 4'h3, 32'h0,        32'h0000F0A5, 1'b1, 1'b0);
        add_vec(OP_LH,  32'h00000100, 32'h0,        32'h8070F0A5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 4'h3, 32'h0,        32'hFFFFF0A5, 1'b1, 1'b0);
        add_vec(OP_SH,  32'h00000202, 32'h00001234, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 4'hC, 32'h12341234, 32'h00000202, 1'b0, 1'b0);
        add_vec(OP_SB,  32'h00000201, 32'h000000AB, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 4'h2, 32'hABABABAB, 32'h00000201, 1'b0, 1'b0);
        add_vec(OP_SW,  32'h00000204, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h00000204, 1'b0, 1'b0);
        add_vec(OP_SB,  32'h00000203, 32'h0000005A, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 4'h8, 32'h5A5A5A5A, 32'h00000203, 1'b0, 1'b0);
        add_vec(OP_SW,  32'h00000300, 32'h01020304, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 5'd2,  1'b1, 1'b1, 4'hF, 32'h01020304, 32'h00000300, 1'b0, 1'b0);
        add_vec(6'h3F,  32'h00000108, 32'h0,        32'h0BADCAFE, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 4'hF, 32'h0,        32'h0BADCAFE, 1'b1, 1'b0);
        add_vec(OP_LW,  32'h00000102, 32'h0,        32'h11111111, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1);
        add_vec(OP_LH,  32'h00000101, 32'h0,        32'h22222222, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1);
        add_vec(6'h00,  32'h0000ABCD, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0, 4'h0, 32'h0,        32'h0000ABCD, 1'b1, 1'b0);
        add_vec(6'h00,  32'h00000077, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0, 4'h0, 32'h0,        32'h00000077, 1'b0, 1'b0);
        run_table();

        // Three wait states before ack.
        drive(6'h00, 32'h0BADF00D, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd20, 1'b0);
        next_edge();
        drive(OP_LW, 32'h00000040, 32'h0, 32'h11223344, 1'b1, 1'b0, 1'b1, 1'b1, 5'd21, 1'b0);
        stall_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            dmem_ack = (k == 3);
            #2;
            if (Stall_MEM) stall_cnt++;
            check("wait_req", 32'(dmem_req), 32'h1);
            check("wait_addr", dmem_addr, 32'h00000040);
            check("wait_be", 32'(dmem_be), 32'hF);
            next_edge();
            if (k < 3) begin
                check("wait_bubble_wb", 32'(do_writeback1_WB), 32'h0);
                check("wait_bubble_hold", Data1_WB, 32'h0BADF00D);
            end
        end
        check("wait_stall_cycles", 32'(stall_cnt), 32'd3);
        check("wait_data", Data1_WB, 32'h11223344);
        check("wait_wreg", 32'(writeRegister1_WB), 32'd21);
        check("wait_wb", 32'(do_writeback1_WB), 32'h1);

        // Timeout: no ack ever.
        drive(OP_LW, 32'h00000080, 32'h0, 32'h99999999, 1'b1, 1'b0, 1'b1, 1'b1, 5'd22, 1'b0);
        stall_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            stalled = Stall_MEM;
            if (stalled) stall_cnt++;
            next_edge();
            if (!stalled) break;
            check("tmo_no_early_fault", 32'(mem_fault), 32'h0);
        end
        check("tmo_stall_cycles", 32'(stall_cnt), 32'(MAX_WAIT));
        check("tmo_fault", 32'(mem_fault), 32'h1);
        check("tmo_wb", 32'(do_writeback1_WB), 32'h0);
        drive(6'h00, 32'h00000055, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd23, 1'b0);
        #2;
        check("tmo_req_dropped", 32'(dmem_req), 32'h0);
        next_edge();
        check("tmo_fault_pulse_end", 32'(mem_fault), 32'h0);
        check("tmo_next_data", Data1_WB, 32'h00000055);

        // Ack arriving in the last allowed WAIT cycle completes.
        drive(OP_LW, 32'h00000084, 32'h0, 32'h55AA55AA, 1'b1, 1'b0, 1'b1, 1'b1, 5'd24, 1'b0);
        for (int k = 0; k < int'(MAX_WAIT); k++) next_edge();
        dmem_ack = 1'b1;
        #2;
        check("lim_stall", 32'(Stall_MEM), 32'h0);
        check("lim_req", 32'(dmem_req), 32'h1);
        next_edge();
        check("lim_fault", 32'(mem_fault), 32'h0);
        check("lim_wb", 32'(do_writeback1_WB), 32'h1);
        check("lim_data", Data1_WB, 32'h55AA55AA);

        // Reset in the middle of a WAIT.
        drive(OP_LW, 32'h00000090, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd25, 1'b0);
        next_edge();
        next_edge();
        RESET = 1'b0;
        #1;
        check("rstw_req", 32'(dmem_req), 32'h0);
        check("rstw_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rstw_data", Data1_WB, 32'h0);
        check("rstw_wb", 32'(do_writeback1_WB), 32'h0);
        next_edge();
        RESET = 1'b1;
        drive(6'h00, 32'h00C0FFEE, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd26, 1'b0);
        #2;
        check("rstw_idle_req", 32'(dmem_req), 32'h0);
        next_edge();
        check("rstw_after_data", Data1_WB, 32'h00C0FFEE);
        check("rstw_after_wb", 32'(do_writeback1_WB), 32'h1);

        // Randomized traffic against the reference model.
        run_random(300);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
